// File: rtl/axil_sync_fifo_gen.sv
// Single-clock FIFO with optional first-word-fall-through read port,
// occupancy/threshold flags, synchronous flush and sticky error flags.
module axil_sync_fifo_gen #(
  parameter int SIZE     = 32,
  parameter int DEPTH    = 64,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     AXI_CLK,
  input  logic                     ARESET,
  input  logic                     FLUSH,
  input  logic                     WR_EN,
  input  logic [SIZE-1:0]          WR_DATA,
  input  logic                     RD_EN,
  output logic [SIZE-1:0]          RD_DATA,
  output logic                     RD_VALID,
  input  logic                     ERR_CLR,
  output logic                     FIFO_FULL,
  output logic                     FIFO_EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   FILL_COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [SIZE-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          wrAccept, rdAccept;
  logic [SIZE-1:0] headData;

  assign FIFO_FULL    = (count_q == CW'(DEPTH));
  assign FIFO_EMPTY   = (count_q == '0);
  assign ALMOST_FULL  = (count_q >= CW'(AF_LEVEL));
  assign ALMOST_EMPTY = (count_q <= CW'(AE_LEVEL));
  assign FILL_COUNT   = count_q;
  assign OVERFLOW     = overflow_q;
  assign UNDERFLOW    = underflow_q;

  assign wrAccept = WR_EN && !FIFO_FULL && !FLUSH;
  assign rdAccept = RD_EN && !FIFO_EMPTY && !FLUSH;
  assign headData = mem[rdPtr_q];

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = (WR_EN && FIFO_FULL && !FLUSH) || (overflow_q && !ERR_CLR);
    underflow_d = (RD_EN && FIFO_EMPTY && !FLUSH) || (underflow_q && !ERR_CLR);
    if (FLUSH) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wrAccept) wrPtr_d = wrPtr_q + AW'(1);
      if (rdAccept) rdPtr_d = rdPtr_q + AW'(1);
      case ({wrAccept, rdAccept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge AXI_CLK or posedge ARESET) begin
    if (ARESET) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; a write coinciding with reset is dropped.
  always_ff @(posedge AXI_CLK) begin
    if (wrAccept && !ARESET) mem[wrPtr_q] <= WR_DATA;
  end

  if (FWFT == 0) begin : gStdRead
    logic [SIZE-1:0] rdData_q, rdData_d;
    logic            rdValid_q, rdValid_d;

    always_comb begin
      rdData_d  = rdAccept ? headData : rdData_q;
      rdValid_d = rdAccept;
    end

    always_ff @(posedge AXI_CLK or posedge ARESET) begin
      if (ARESET) begin
        rdData_q  <= '0;
        rdValid_q <= 1'b0;
      end else begin
        rdData_q  <= rdData_d;
        rdValid_q <= rdValid_d;
      end
    end

    assign RD_DATA  = rdData_q;
    assign RD_VALID = rdValid_q;
  end else begin : gFwftRead
    // Head is shown combinationally; masked to zero so reset/empty reads as 0.
    assign RD_DATA  = FIFO_EMPTY ? '0 : headData;
    assign RD_VALID = !FIFO_EMPTY;
  end

endmodule

// File: tb/tb_axil_sync_fifo_gen.sv
// Self-checking bench: three FIFO configurations share one stimulus stream and
// are each compared against a list-based reference model plus directed checks.
module tb_axil_sync_fifo_gen;

  logic       clk;
  logic       areset;
  logic       flush;
  logic       wrEn;
  logic       rdEn;
  logic       errClr;
  logic [7:0] wrData;

  logic [7:0] oRdData [3];
  logic [3:0] oFill   [3];
  logic       oRdValid[3];
  logic       oFull   [3];
  logic       oEmpty  [3];
  logic       oAf     [3];
  logic       oAe     [3];
  logic       oOvf    [3];
  logic       oUdf    [3];

  int checks;
  int errors;

  // Reference model: each FIFO is an ordered list with element 0 as the head.
  logic [7:0] mList [3][8];
  int         mCnt  [3];
  logic [7:0] mRd   [3];
  logic       mRv   [3];
  logic       mOvf  [3];
  logic       mUdf  [3];
  int         mDepth[3];
  int         mFwft [3];
  int         mAf   [3];
  int         mAe   [3];

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] data;
    int         cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       rv;
    logic [7:0] rdat;
  } vec_t;

  vec_t tbl[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DEPTH 4 standard; 1: DEPTH 8 FWFT; 2: DEPTH 8 standard.
  for (genvar g = 0; g < 3; g++) begin : gDut
    localparam int D  = (g == 0) ? 4 : 8;
    localparam int FW = (g == 1) ? 1 : 0;
    localparam int AF = (g == 0) ? 3 : 6;
    localparam int AE = (g == 0) ? 1 : 2;
    logic [$clog2(D):0] fc;
    logic [7:0] rdat;
    logic rv, ff, fe, af, ae, ov, un;

    axil_sync_fifo_gen #(
      .SIZE(8), .DEPTH(D), .FWFT(FW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
      .AXI_CLK(clk), .ARESET(areset), .FLUSH(flush),
      .WR_EN(wrEn), .WR_DATA(wrData), .RD_EN(rdEn),
      .RD_DATA(rdat), .RD_VALID(rv), .ERR_CLR(errClr),
      .FIFO_FULL(ff), .FIFO_EMPTY(fe), .ALMOST_FULL(af), .ALMOST_EMPTY(ae),
      .FILL_COUNT(fc), .OVERFLOW(ov), .UNDERFLOW(un)
    );

    assign oFill[g]    = 4'(fc);
    assign oRdData[g]  = rdat;
    assign oRdValid[g] = rv;
    assign oFull[g]    = ff;
    assign oEmpty[g]   = fe;
    assign oAf[g]      = af;
    assign oAe[g]      = ae;
    assign oOvf[g]     = ov;
    assign oUdf[g]     = un;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 3; i++) begin
      mCnt[i] = 0;
      mRd[i]  = 8'h00;
      mRv[i]  = 1'b0;
      mOvf[i] = 1'b0;
      mUdf[i] = 1'b0;
    end
  endfunction

  function automatic void modelEdge();
    for (int i = 0; i < 3; i++) begin
      bit full, empty, nOvf, nUdf;
      full  = (mCnt[i] == mDepth[i]);
      empty = (mCnt[i] == 0);
      nOvf  = (wrEn && full && !flush) || (mOvf[i] && !errClr);
      nUdf  = (rdEn && empty && !flush) || (mUdf[i] && !errClr);
      mRv[i] = 1'b0;
      if (flush) begin
        mCnt[i] = 0;
      end else begin
        if (rdEn && !empty) begin
          mRd[i] = mList[i][0];
          mRv[i] = 1'b1;
          for (int k = 0; k < 7; k++) mList[i][k] = mList[i][k+1];
          mCnt[i]--;
        end
        if (wrEn && !full) begin
          mList[i][mCnt[i]] = wrData;
          mCnt[i]++;
        end
      end
      mOvf[i] = nOvf;
      mUdf[i] = nUdf;
    end
  endfunction

  task automatic checkOutput();
    for (int i = 0; i < 3; i++) begin
      int expRd, expRv;
      if (mFwft[i] != 0) begin
        expRd = (mCnt[i] != 0) ? int'(mList[i][0]) : 0;
        expRv = (mCnt[i] != 0) ? 1 : 0;
      end else begin
        expRd = int'(mRd[i]);
        expRv = int'(mRv[i]);
      end
      check($sformatf("u%0d.rdData", i),  oRdData[i],  expRd);
      check($sformatf("u%0d.rdValid", i), oRdValid[i], expRv);
      check($sformatf("u%0d.fill", i),    oFill[i],    mCnt[i]);
      check($sformatf("u%0d.full", i),    oFull[i],    int'(mCnt[i] == mDepth[i]));
      check($sformatf("u%0d.empty", i),   oEmpty[i],   int'(mCnt[i] == 0));
      check($sformatf("u%0d.aFull", i),   oAf[i],      int'(mCnt[i] >= mAf[i]));
      check($sformatf("u%0d.aEmpty", i),  oAe[i],      int'(mCnt[i] <= mAe[i]));
      check($sformatf("u%0d.ovf", i),     oOvf[i],     int'(mOvf[i]));
      check($sformatf("u%0d.udf", i),     oUdf[i],     int'(mUdf[i]));
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic fl,
                               input logic ec, input logic [7:0] d);
    wrEn   = wr;
    rdEn   = rd;
    flush  = fl;
    errClr = ec;
    wrData = d;
    @(posedge clk);
    if (!areset) modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic checkResetValues(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s.u%0d.fill", tag, i),    oFill[i],    0);
      check($sformatf("%s.u%0d.empty", tag, i),   oEmpty[i],   1);
      check($sformatf("%s.u%0d.aEmpty", tag, i),  oAe[i],      1);
      check($sformatf("%s.u%0d.full", tag, i),    oFull[i],    0);
      check($sformatf("%s.u%0d.aFull", tag, i),   oAf[i],      0);
      check($sformatf("%s.u%0d.rdData", tag, i),  oRdData[i],  0);
      check($sformatf("%s.u%0d.rdValid", tag, i), oRdValid[i], 0);
      check($sformatf("%s.u%0d.ovf", tag, i),     oOvf[i],     0);
      check($sformatf("%s.u%0d.udf", tag, i),     oUdf[i],     0);
    end
  endtask

  initial begin
    logic [7:0] sent[$];
    logic [7:0] d;
    checks = 0;
    errors = 0;
    mDepth = '{4, 8, 8};
    mFwft  = '{0, 1, 0};
    mAf    = '{3, 6, 6};
    mAe    = '{1, 2, 2};

    tbl[0] = '{1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'hA2, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 8'hA3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 8'hA4, 4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{1'b1, 1'b0, 8'hA5, 4, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1};
    tbl[6] = '{1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA2};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3};
    tbl[8] = '{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA4};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA4};

    areset = 1'b1;
    flush  = 1'b0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    errClr = 1'b0;
    wrData = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    @(negedge clk);
    areset = 1'b0;

    // Depth-4 fill, overflow on the fifth write, then drain in order.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(tbl[v].wr, tbl[v].rd, 1'b0, 1'b0, tbl[v].data);
      check($sformatf("tbl%0d.fill", v),    oFill[0],    tbl[v].cnt);
      check($sformatf("tbl%0d.full", v),    oFull[0],    tbl[v].full);
      check($sformatf("tbl%0d.empty", v),   oEmpty[0],   tbl[v].empty);
      check($sformatf("tbl%0d.ovf", v),     oOvf[0],     tbl[v].ovf);
      check($sformatf("tbl%0d.rdValid", v), oRdValid[0], tbl[v].rv);
      check($sformatf("tbl%0d.rdData", v),  oRdData[0],  tbl[v].rdat);
    end

    // Drain whatever the deeper instances still hold, then clear errors.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    check("errclr.ovf", oOvf[0], 0);

    // FWFT: data appears the cycle after the write edge without a read.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
    check("fwft.rdData", oRdData[1], 8'h55);
    check("fwft.rdValid", oRdValid[1], 1);
    check("fwft.empty0", oEmpty[1], 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("fwft.empty1", oEmpty[1], 1);
    check("fwft.rdValid0", oRdValid[1], 0);
    check("std.popData", oRdData[2], 8'h55);

    // Underflow: sticky, set wins over clear, clear alone drops it.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("udf.set", oUdf[2], 1);
    check("udf.rdHeld", oRdData[2], 8'h55);
    check("udf.rdValid", oRdValid[2], 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    check("udf.setWins", oUdf[2], 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("udf.cleared", oUdf[2], 0);

    // Fill to 6, then flush with a concurrent write.
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h10 + k));
    check("af.fill6", oFill[2], 6);
    check("af.set", oAf[2], 1);
    check("af.ae0", oAe[2], 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hEE);
    check("flush.fill", oFill[2], 0);
    check("flush.empty", oEmpty[2], 1);
    check("flush.aEmpty", oAe[2], 1);
    check("flush.fwftValid", oRdValid[1], 0);
    check("flush.ovfKept", oOvf[0], 1);
    check("flush.stdHeld", oRdData[2], 8'h55);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    check("flush.writeDropped", oFill[2], 0);

    // Paired read/write across wrap-around at counts 1 and 7.
    d = 8'h20;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, d);
    sent.push_back(d);
    for (int p = 0; p < 20; p++) begin
      if (p == 10) begin
        for (int k = 0; k < 6; k++) begin
          d = d + 8'd1;
          applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, d);
          sent.push_back(d);
        end
      end
      d = d + 8'd1;
      sent.push_back(d);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, d);
      check($sformatf("pair%0d.fill", p), oFill[2], (p < 10) ? 1 : 7);
      check($sformatf("pair%0d.rdData", p), oRdData[2], sent.pop_front());
      check($sformatf("pair%0d.rdValid", p), oRdValid[2], 1);
    end

    // Asynchronous reset mid-burst at count 5.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h60 + k));
    check("burst.fill5", oFill[2], 5);
    wrEn   = 1'b1;
    wrData = 8'h77;
    #2;
    areset = 1'b1;
    modelReset();
    #1;
    checkResetValues("asyncRst");
    @(posedge clk);
    #1;
    checkResetValues("rstHeld");
    #3;
    wrEn   = 1'b0;
    areset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    check("postRst.fill", oFill[2], 1);
    check("postRst.fwft", oRdData[1], 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    check("postRst.std", oRdData[2], 8'h3C);
    check("postRst.stdValid", oRdValid[2], 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(logic'(($urandom % 10) < 6), logic'(($urandom % 10) < 5),
                    logic'(($urandom % 32) == 0), logic'(($urandom % 16) == 0),
                    8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
